// File: rtl/pc6001_kbd_pkg.sv
// Shared constants and types for the PC-6001 PS/2 keyboard receiver.
package pc6001_kbd_pkg;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;

  // {kana_page, shift, ext, scancode}
  localparam int XLAT_AW = 11;

  typedef struct packed {
    logic       graph;
    logic [7:0] code;
  } kbd_entry_t;

endpackage

// File: rtl/pc6001_kbd_xlat.sv
// Set-2 scancode to PC-6001 key code ROM: synchronous read, registered output.
module pc6001_kbd_xlat
  import pc6001_kbd_pkg::*;
(
  input  logic               clk,
  input  logic [XLAT_AW-1:0] addr,
  output logic [7:0]         data
);

  // Constant table so the core builds without an external memory image.
  // Page 0: unshifted/shifted ASCII-style codes; page 1 (addr[10]): kana.
  function automatic logic [7:0] rom_word(input logic [XLAT_AW-1:0] a);
    logic       kana_pg;
    logic       shift;
    logic       ext;
    logic [7:0] code;
    logic       letter;
    logic [4:0] li;
    logic [7:0] w;
    kana_pg = a[10];
    shift   = a[9];
    ext     = a[8];
    code    = a[7:0];
    letter  = 1'b1;
    li      = 5'd0;
    w       = 8'h00;
    case (code)
      8'h1C: li = 5'd0;  8'h32: li = 5'd1;  8'h21: li = 5'd2;  8'h23: li = 5'd3;
      8'h24: li = 5'd4;  8'h2B: li = 5'd5;  8'h34: li = 5'd6;  8'h33: li = 5'd7;
      8'h43: li = 5'd8;  8'h3B: li = 5'd9;  8'h42: li = 5'd10; 8'h4B: li = 5'd11;
      8'h3A: li = 5'd12; 8'h31: li = 5'd13; 8'h44: li = 5'd14; 8'h4D: li = 5'd15;
      8'h15: li = 5'd16; 8'h2D: li = 5'd17; 8'h1B: li = 5'd18; 8'h2C: li = 5'd19;
      8'h3C: li = 5'd20; 8'h2A: li = 5'd21; 8'h1D: li = 5'd22; 8'h22: li = 5'd23;
      8'h35: li = 5'd24; 8'h1A: li = 5'd25;
      default: letter = 1'b0;
    endcase
    if (ext) begin
      case (code)
        8'h75:   w = 8'h1E;
        8'h72:   w = 8'h1F;
        8'h6B:   w = 8'h1D;
        8'h74:   w = 8'h1C;
        8'h5A:   w = 8'h0D;
        default: w = 8'h00;
      endcase
    end else if (letter) begin
      if (kana_pg)    w = 8'hB1 + {3'b000, li};
      else if (shift) w = 8'h61 + {3'b000, li};
      else            w = 8'h41 + {3'b000, li};
    end else begin
      case (code)
        8'h29:   w = 8'h20;
        8'h5A:   w = 8'h0D;
        8'h66:   w = 8'h08;
        default: w = 8'h00;
      endcase
    end
    return w;
  endfunction

  always_ff @(posedge clk) begin
    data <= rom_word(addr);
  end

endmodule

// File: rtl/pc6001_kbd.sv
// PS/2 key-event receiver: modifier tracking, scancode translation and a
// small key FIFO drained by the keyboard sub-CPU.
module pc6001_kbd
  import pc6001_kbd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  output logic        key_valid,
  output logic [7:0]  key_code,
  output logic        key_graph,
  input  logic        key_ack,
  output logic        mod_shift,
  output logic        mod_ctrl,
  output logic        mod_graph,
  output logic        kana_lock,
  output logic        overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic       tog_q;
  logic       armed_q;
  logic       ev;
  logic       ev_make;
  logic       ev_ext;
  logic [7:0] ev_code;
  logic       is_lshift, is_rshift, is_ctrl, is_lalt, is_ralt, is_mod;
  logic       lshift_q, rshift_q;

  assign ev_make = ps2_key[9];
  assign ev_ext  = ps2_key[8];
  assign ev_code = ps2_key[7:0];
  // armed_q holds off detection for one cycle after reset so a toggle that
  // happened while in reset is absorbed rather than replayed.
  assign ev      = armed_q && (ps2_key[10] != tog_q);

  assign is_lshift = !ev_ext && (ev_code == SC_LSHIFT);
  assign is_rshift = !ev_ext && (ev_code == SC_RSHIFT);
  assign is_ctrl   = (ev_code == SC_CTRL);
  assign is_lalt   = !ev_ext && (ev_code == SC_ALT);
  assign is_ralt   = ev_ext && (ev_code == SC_ALT);
  assign is_mod    = is_lshift | is_rshift | is_ctrl | is_lalt | is_ralt;

  always_ff @(posedge clk) begin
    tog_q <= ps2_key[10];
    if (reset) begin
      armed_q   <= 1'b0;
      lshift_q  <= 1'b0;
      rshift_q  <= 1'b0;
      mod_ctrl  <= 1'b0;
      mod_graph <= 1'b0;
      kana_lock <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (ev) begin
        if (is_lshift) lshift_q  <= ev_make;
        if (is_rshift) rshift_q  <= ev_make;
        if (is_ctrl)   mod_ctrl  <= ev_make;
        if (is_lalt)   mod_graph <= ev_make;
        if (is_ralt && ev_make) kana_lock <= ~kana_lock;
      end
    end
  end

  assign mod_shift = lshift_q | rshift_q;

  // Translation stage: ROM samples the address on the detect edge, and the
  // pipeline valid/graph bits travel alongside the ROM output register.
  logic [XLAT_AW-1:0] xlat_addr;
  logic [7:0]         rom_data;
  logic               p_valid;
  logic               p_graph;

  assign xlat_addr = kana_lock ? {1'b1, 1'b1, ev_ext, ev_code}
                               : {1'b0, mod_shift, ev_ext, ev_code};

  pc6001_kbd_xlat u_xlat (
    .clk  (clk),
    .addr (xlat_addr),
    .data (rom_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid <= 1'b0;
      p_graph <= 1'b0;
    end else begin
      p_valid <= ev && ev_make && !is_mod;
      p_graph <= mod_graph;
    end
  end

  // Sub-CPU handshake: key_valid is high whenever the FIFO holds an entry and
  // key_code/key_graph show the head; a one-cycle key_ack consumes the head
  // on that edge and the next entry (if any) is shown right after it. An ack
  // seen while key_valid is low has no effect.
  kbd_entry_t        mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              push_req, push, pop, full;
  kbd_entry_t        head;

  assign full     = (count == CW'(DEPTH));
  assign pop      = key_ack && (count != '0) && !reset;
  assign push_req = p_valid && (rom_data != 8'h00) && !reset;
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{graph: p_graph, code: rom_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (push_req && !push) overflow <= 1'b1;
    end
  end

  assign head      = mem[rd_ptr];
  assign key_valid = (count != '0);
  assign key_code  = key_valid ? head.code : 8'h00;
  assign key_graph = key_valid ? head.graph : 1'b0;

endmodule

// File: tb/tb_pc6001_kbd.sv
// Self-checking bench for pc6001_kbd: directed scenarios plus randomized
// key traffic against a behavioural keyboard/FIFO model.
module tb_pc6001_kbd;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] ps2_key = '0;
  logic        key_ack = 1'b0;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        key_graph;
  logic        mod_shift, mod_ctrl, mod_graph, kana_lock, overflow;

  pc6001_kbd #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_key   (ps2_key),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_graph (key_graph),
    .key_ack   (key_ack),
    .mod_shift (mod_shift),
    .mod_ctrl  (mod_ctrl),
    .mod_graph (mod_graph),
    .kana_lock (kana_lock),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [8:0] exp_q[$];
  logic       m_lshift, m_rshift, m_ctrl, m_graph, m_kana, m_ovf;
  logic       tog = 1'b0;

  // Set-2 scancodes of letters A..Z in alphabet order
  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                               8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                               8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                               8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  function automatic logic [7:0] m_xlat(input logic shift, input logic kana,
                                        input logic ext, input logic [7:0] c);
    int idx;
    idx = -1;
    for (int i = 0; i < 26; i++) if (letters[i] == c) idx = i;
    if (ext) begin
      case (c)
        8'h75: return 8'h1E;
        8'h72: return 8'h1F;
        8'h6B: return 8'h1D;
        8'h74: return 8'h1C;
        8'h5A: return 8'h0D;
        default: return 8'h00;
      endcase
    end
    if (idx >= 0) begin
      if (kana)  return 8'(8'hB1 + idx);
      if (shift) return 8'(8'h61 + idx);
      return 8'(8'h41 + idx);
    end
    case (c)
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      8'h66: return 8'h08;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_clear();
    m_lshift = 0; m_rshift = 0; m_ctrl = 0; m_graph = 0; m_kana = 0; m_ovf = 0;
    exp_q.delete();
  endtask

  task automatic model_event(input logic mk, input logic ex, input logic [7:0] c);
    logic [7:0] v;
    if (!ex && c == 8'h12)      m_lshift = mk;
    else if (!ex && c == 8'h59) m_rshift = mk;
    else if (c == 8'h14)        m_ctrl = mk;
    else if (!ex && c == 8'h11) m_graph = mk;
    else if (ex && c == 8'h11) begin
      if (mk) m_kana = ~m_kana;
    end else if (mk) begin
      v = m_xlat(m_lshift | m_rshift, m_kana, ex, c);
      if (v != 8'h00) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({m_graph, v});
        else m_ovf = 1'b1;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic drive_event(input logic mk, input logic ex, input logic [7:0] c);
    tog = ~tog;
    ps2_key = {tog, mk, ex, c};
    model_event(mk, ex, c);
    @(negedge clk);
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    do_reset();
    @(negedge clk);
    if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", key_valid); end checks++;
    if (key_code !== 8'h00) begin errors++; $display("FAIL reset_code: got %h want 00", key_code); end checks++;
    if (key_graph !== 1'b0) begin errors++; $display("FAIL reset_graph: got %b want 0", key_graph); end checks++;
    if ({mod_shift, mod_ctrl, mod_graph, kana_lock} !== 4'b0) begin
      errors++; $display("FAIL reset_mods: got %b want 0000", {mod_shift, mod_ctrl, mod_graph, kana_lock});
    end checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end checks++;
  endtask

  task automatic test_basic();
    drive_event(1, 0, 8'h1C);
    if (key_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_e0: got %b want 0", key_valid); end checks++;
    @(negedge clk);
    if (key_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_e1: got %b want 1", key_valid); end checks++;
    if (key_code !== 8'h41) begin errors++; $display("FAIL basic_code: got %h want 41", key_code); end checks++;
    if (key_graph !== 1'b0) begin errors++; $display("FAIL basic_graph: got %b want 0", key_graph); end checks++;
    ack_pulse();
    if (key_valid !== 1'b0) begin errors++; $display("FAIL basic_pop_valid: got %b want 0", key_valid); end checks++;
    if (key_code !== 8'h00) begin errors++; $display("FAIL basic_pop_code: got %h want 00", key_code); end checks++;
  endtask

  task automatic test_shift();
    drive_event(1, 0, 8'h12);
    if (mod_shift !== 1'b1) begin errors++; $display("FAIL shift_set: got %b want 1", mod_shift); end checks++;
    drive_event(1, 0, 8'h1C);
    drive_event(0, 0, 8'h12);
    if (mod_shift !== 1'b0) begin errors++; $display("FAIL shift_clr: got %b want 0", mod_shift); end checks++;
    if (key_code !== 8'h61) begin errors++; $display("FAIL shift_code: got %h want 61", key_code); end checks++;
    ack_pulse();
    if (key_valid !== 1'b0) begin errors++; $display("FAIL shift_single: got %b want 0", key_valid); end checks++;
  endtask

  task automatic test_modifiers();
    drive_event(1, 1, 8'h11);
    if (kana_lock !== 1'b1) begin errors++; $display("FAIL kana_on: got %b want 1", kana_lock); end checks++;
    drive_event(1, 0, 8'h1C);
    @(negedge clk);
    if (key_code !== 8'hB1) begin errors++; $display("FAIL kana_code: got %h want b1", key_code); end checks++;
    ack_pulse();
    drive_event(0, 1, 8'h11);
    if (kana_lock !== 1'b1) begin errors++; $display("FAIL kana_break: got %b want 1", kana_lock); end checks++;
    drive_event(1, 1, 8'h11);
    if (kana_lock !== 1'b0) begin errors++; $display("FAIL kana_off: got %b want 0", kana_lock); end checks++;
    drive_event(1, 0, 8'h11);
    if (mod_graph !== 1'b1) begin errors++; $display("FAIL graph_set: got %b want 1", mod_graph); end checks++;
    drive_event(1, 0, 8'h1C);
    @(negedge clk);
    if (key_graph !== 1'b1 || key_code !== 8'h41) begin
      errors++; $display("FAIL graph_entry: got %b/%h want 1/41", key_graph, key_code);
    end checks++;
    drive_event(0, 0, 8'h11);
    if (mod_graph !== 1'b0) begin errors++; $display("FAIL graph_clr: got %b want 0", mod_graph); end checks++;
    ack_pulse();
    drive_event(1, 1, 8'h14);
    if (mod_ctrl !== 1'b1) begin errors++; $display("FAIL ctrl_set: got %b want 1", mod_ctrl); end checks++;
    drive_event(0, 0, 8'h14);
    if (mod_ctrl !== 1'b0) begin errors++; $display("FAIL ctrl_clr: got %b want 0", mod_ctrl); end checks++;
    drive_event(1, 0, 8'h59);
    if (mod_shift !== 1'b1) begin errors++; $display("FAIL rshift_set: got %b want 1", mod_shift); end checks++;
    drive_event(0, 0, 8'h59);
    @(negedge clk);
    if (mod_shift !== 1'b0 || key_valid !== 1'b0) begin
      errors++; $display("FAIL mod_no_entry: got shift=%b valid=%b want 0/0", mod_shift, key_valid);
    end checks++;
  endtask

  task automatic test_overflow();
    logic [7:0] c;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive_event($urandom_range(0, 1) == 1, 0, 8'h12);
      drive_event(1, 0, letters[$urandom_range(0, 25)]);
    end
    @(negedge clk);
    if (overflow !== 1'b0 || key_valid !== 1'b1) begin
      errors++; $display("FAIL ovf_fill: got ovf=%b valid=%b want 0/1", overflow, key_valid);
    end checks++;
    // Push lands on the same edge as the ack
    c = letters[$urandom_range(0, 25)];
    tog = ~tog;
    ps2_key = {tog, 1'b1, 1'b0, c};
    @(negedge clk);
    key_ack = 1'b1;
    void'(exp_q.pop_front());
    model_event(1, 0, c);
    @(negedge clk);
    key_ack = 1'b0;
    if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_simul: got %b want %b", overflow, m_ovf); end checks++;
    drive_event(1, 0, letters[$urandom_range(0, 25)]);
    @(negedge clk);
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end checks++;
    for (int i = 0; i < DEPTH; i++) begin
      if (key_valid !== 1'b1 || {key_graph, key_code} !== exp_q[0]) begin
        errors++; $display("FAIL ovf_drain%0d: got %b/%h want 1/%h", i, key_valid, {key_graph, key_code}, exp_q[0]);
      end checks++;
      ack_pulse();
    end
    if (key_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", key_valid); end checks++;
  endtask

  task automatic test_back_to_back();
    drive_event(0, 0, 8'h12);
    for (int i = 0; i < 5; i++) begin
      logic [7:0] c;
      c = letters[$urandom_range(0, 25)];
      tog = ~tog;
      ps2_key = {tog, 1'b1, 1'b0, c};
      model_event(1, 0, c);
      @(negedge clk);
    end
    @(negedge clk);
    key_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (key_valid !== 1'b1 || {key_graph, key_code} !== exp_q[0]) begin
        errors++; $display("FAIL b2b_%0d: got %b/%h want 1/%h", i, key_valid, {key_graph, key_code}, exp_q[0]);
      end checks++;
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    key_ack = 1'b0;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", key_valid); end checks++;
  endtask

  task automatic test_reset_mid();
    drive_event(1, 0, 8'h11);
    drive_event(1, 0, 8'h1C);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    // Toggle arrives on the same cycle reset drops: must be absorbed
    reset = 1'b0;
    tog = ~tog;
    ps2_key = {tog, 1'b1, 1'b0, 8'h1C};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (key_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid%0d: got %b want 0", i, key_valid); end checks++;
    end
    if (mod_graph !== 1'b0) begin errors++; $display("FAIL rstmid_graph: got %b want 0", mod_graph); end checks++;
    drive_event(1, 0, 8'h1C);
    @(negedge clk);
    if (key_valid !== 1'b1 || key_code !== 8'h41) begin
      errors++; $display("FAIL rstmid_after: got %b/%h want 1/41", key_valid, key_code);
    end checks++;
    ack_pulse();
  endtask

  task automatic test_unmapped();
    for (int i = 0; i < 3; i++) begin
      ack_pulse();
      if (key_valid !== 1'b0) begin errors++; $display("FAIL empty_ack%0d: got %b want 0", i, key_valid); end checks++;
    end
    drive_event(1, 0, 8'h76);
    for (int i = 0; i < 3; i++) begin
      if (key_valid !== 1'b0) begin errors++; $display("FAIL unmapped%0d: got %b want 0", i, key_valid); end checks++;
      @(negedge clk);
    end
    drive_event(1, 0, 8'h1C);
    @(negedge clk);
    if (key_valid !== 1'b1 || key_code !== 8'h41) begin
      errors++; $display("FAIL unmapped_next: got %b/%h want 1/41", key_valid, key_code);
    end checks++;
    ack_pulse();
    if (key_valid !== 1'b0) begin errors++; $display("FAIL unmapped_pop: got %b want 0", key_valid); end checks++;
  endtask

  task automatic test_random();
    logic [8:0] specials [4] = '{9'h029, 9'h076, 9'h175, 9'h014};
    logic       mk, ex;
    logic [7:0] c;
    int         r;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      r  = $urandom_range(0, 9);
      ex = 1'b0;
      if (r <= 4)      c = letters[$urandom_range(0, 25)];
      else if (r == 5) c = 8'h12;
      else if (r == 6) c = 8'h59;
      else if (r == 7) c = 8'h11;
      else if (r == 8) begin ex = 1'b1; c = 8'h11; end
      else begin
        r  = $urandom_range(0, 3);
        ex = specials[r][8];
        c  = specials[r][7:0];
      end
      mk = ($urandom_range(0, 3) != 0);
      drive_event(mk, ex, c);
      if ({mod_shift, mod_ctrl, mod_graph, kana_lock} !== {m_lshift | m_rshift, m_ctrl, m_graph, m_kana}) begin
        errors++; $display("FAIL rnd_mods%0d: got %b want %b", n, {mod_shift, mod_ctrl, mod_graph, kana_lock},
                           {m_lshift | m_rshift, m_ctrl, m_graph, m_kana});
      end checks++;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        if (key_valid !== 1'b1 || {key_graph, key_code} !== exp_q[0]) begin
          errors++; $display("FAIL rnd_head%0d: got %b/%h want 1/%h", n, key_valid, {key_graph, key_code}, exp_q[0]);
        end checks++;
      end else begin
        if (key_valid !== 1'b0) begin errors++; $display("FAIL rnd_empty%0d: got %b want 0", n, key_valid); end checks++;
      end
      if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf%0d: got %b want %b", n, overflow, m_ovf); end checks++;
      if ($urandom_range(0, 2) == 0) ack_pulse();
    end
    while (exp_q.size() > 0) begin
      if ({key_graph, key_code} !== exp_q[0]) begin
        errors++; $display("FAIL rnd_drain: got %h want %h", {key_graph, key_code}, exp_q[0]);
      end checks++;
      ack_pulse();
    end
    if (key_valid !== 1'b0) begin errors++; $display("FAIL rnd_final: got %b want 0", key_valid); end checks++;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_shift();
    test_modifiers();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_unmapped();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
